fsm101_frame_ctrl: RTL and testbench
====================================

// Module: fsm101_frame_ctrl
// PURPOSE
//  Sequences a 4-state one-hot Moore "101" detector over a handshaked serial bit stream.
//  Owns the state register and cuts the stream into frames of FRAME_LEN bits.
//  Counts detector hits per frame and returns one result per frame on a valid/ready port.
//  Sits between a serial bit source and a downstream consumer of per-frame hit counts.
// PARAMETERS
//  FRAME_LEN  16  bits per frame; must be >= 1
//  CNT_W      8   width of the per-frame hit counter; must be >= 1
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  reset      in   1      synchronous reset, active-high
//  in_valid   in   1      in_bit is valid this cycle
//  in_bit     in   1      serial input bit
//  in_ready   out  1      block accepts in_bit this cycle
//  abort      in   1      discard the current frame
//  state      out  4      one-hot state {D,C,B,A}; A=bit0, D=bit3
//  hit        out  1      1-cycle pulse: the accepted bit moved the FSM into D
//  res_valid  out  1      frame result is available
//  res_ready  in   1      consumer takes the result
//  res_hits   out  CNT_W  hits in the frame, saturating
//  res_sat    out  1      the hit count saturated in this frame
// BEHAVIOUR
//  - Reset (sync, highest priority): state=4'b0001 (A), hit=0, res_valid=0, res_hits=0, res_sat=0.
//    Reset also clears the bit counter and the hit accumulator.
//  - in_ready = ~res_valid (combinational). While a result is pending, no bit is accepted.
//    in_valid is ignored while in_ready=0.
//  - Accept: in_valid & in_ready at a rising edge. Only an accept advances the FSM.
//  - FSM transitions, applied on accept:
//      A: 0->A, 1->B
//      B: 0->C, 1->B
//      C: 0->A, 1->D
//      D: 0->C, 1->B
//  - Detector output is a Moore output: it is 1 in state D.
//  - Without an accept, state holds and hit=0.
//  - hit is registered. It is 1 in the cycle after an accept whose next state is D; otherwise 0.
//  - Accumulator: +1 on each hit-producing accept.
//    It saturates at 2^CNT_W-1; the first increment attempted at the maximum sets a sat flag.
//  - Bit counter: counts 0..FRAME_LEN-1 on each accept.
//  - Frame end is the accept of bit FRAME_LEN-1. At that same edge:
//    - res_valid<=1;
//    - res_hits<=final count, including any hit from the last bit; res_sat<=final sat flag;
//    - state<=A; frames never overlap, even if the FSM would have reached D or C;
//    - accumulator, sat flag and bit counter <=0;
//    - hit still pulses if the last bit produced a hit.
//  - Result handshake: res_valid & res_ready at an edge clears res_valid.
//    in_ready rises in the cycle after that edge.
//    res_hits and res_sat hold stable while res_valid=1.
//  - abort (priority below reset, above accept):
//    - state<=A; accumulator, sat flag and bit counter <=0; hit<=0;
//    - a bit offered in the same cycle is dropped;
//    - a pending result (res_valid=1) is kept untouched and is not cancelled.
//  - Latency: accept at edge k updates state at edge k, and hit is high during cycle k+1.
//    The last bit at edge k gives res_valid=1 in cycle k+1.
//  - state is always exactly one-hot.
// TESTING
//  T1 reset: assert reset 2 cycles -> state=0001, hit=0, res_valid=0, in_ready=1, res_hits=0.
//  T2 FRAME_LEN=8, bits 1,0,1,0,1,1,0,1 back-to-back
//     -> hits after bits 3,5,8; res_hits=3, res_sat=0; state=0001 after the frame.
//  T3 backpressure: result pending, res_ready=0 for 5 cycles, in_valid=1
//     -> in_ready=0, no state change, res_hits stable.
//     Then res_ready=1 -> res_valid=0 next cycle, in_ready=1.
//  T4 no overlap: frame 1 ends ...,1,0 (FSM would be in C); frame 2 starts with 1
//     -> state=B, no hit.
//  T5 abort after 5 of 8 bits, then 8 bits 1,0,1,0,0,0,0,0
//     -> res_hits=1 (aborted bits not counted).
//  T6 CNT_W=2, FRAME_LEN=16, bits 1,0 repeated -> 7 hits; res_hits=3, res_sat=1.

Source files
------------

// File: rtl/fsm101_frame_ctrl.sv
// Frame-based "101" detector: a one-hot Moore FSM advanced by accepted serial bits, with
// per-frame saturating hit counts returned on a valid/ready result port.
module fsm101_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             abort,
  output logic [3:0]       state,
  output logic             hit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_hits,
  output logic             res_sat
);

  localparam int unsigned BitW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BitW-1:0]  LastIdx = BitW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [3:0] {
    StA = 4'b0001,
    StB = 4'b0010,
    StC = 4'b0100,
    StD = 4'b1000
  } state_e;

  state_e            state_q, state_d, fsm_nxt;
  logic              hit_q, hit_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  res_hits_q, res_hits_d;
  logic              res_sat_q, res_sat_d;
  logic [CNT_W-1:0]  acc_q, acc_d, acc_new;
  logic              sat_q, sat_d, sat_new;
  logic [BitW-1:0]   cnt_q, cnt_d;
  logic              accept;

  always_comb begin
    fsm_nxt = StA;
    unique case (state_q)
      StA:     fsm_nxt = in_bit ? StB : StA;
      StB:     fsm_nxt = in_bit ? StB : StC;
      StC:     fsm_nxt = in_bit ? StD : StA;
      StD:     fsm_nxt = in_bit ? StB : StC;
      default: fsm_nxt = StA;
    endcase
  end

  always_comb begin
    accept  = in_valid & ~res_valid_q & ~abort;
    acc_new = acc_q;
    sat_new = sat_q;
    if (fsm_nxt == StD) begin
      // Count sticks at the maximum; the overflowing attempt only raises the flag.
      if (acc_q == CntMax) sat_new = 1'b1;
      else                 acc_new = acc_q + CNT_W'(1);
    end

    state_d     = state_q;
    hit_d       = 1'b0;
    res_valid_d = res_valid_q;
    res_hits_d  = res_hits_q;
    res_sat_d   = res_sat_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    if (abort) begin
      state_d = StA;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      hit_d = (fsm_nxt == StD);
      if (cnt_q == LastIdx) begin
        // Frames never overlap: the detector restarts from A for the next frame.
        state_d     = StA;
        acc_d       = '0;
        sat_d       = 1'b0;
        cnt_d       = '0;
        res_valid_d = 1'b1;
        res_hits_d  = acc_new;
        res_sat_d   = sat_new;
      end else begin
        state_d = fsm_nxt;
        acc_d   = acc_new;
        sat_d   = sat_new;
        cnt_d   = cnt_q + BitW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StA;
      hit_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_hits_q  <= '0;
      res_sat_q   <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      res_valid_q <= res_valid_d;
      res_hits_q  <= res_hits_d;
      res_sat_q   <= res_sat_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = ~res_valid_q;
  assign state     = state_q;
  assign hit       = hit_q;
  assign res_valid = res_valid_q;
  assign res_hits  = res_hits_q;
  assign res_sat   = res_sat_q;

endmodule

// File: tb/tb_fsm101_frame_ctrl.sv
// Bench for fsm101_frame_ctrl: two instances (8-bit frames / wide counter, 16-bit frames /
// 2-bit counter) share the bit stream and are checked every cycle against a frame-level model.
module tb_fsm101_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_bit, abort;
  logic       res_ready0, res_ready1;
  logic       in_ready0, in_ready1, hit0, hit1, res_valid0, res_valid1, res_sat0, res_sat1;
  logic [3:0] state0, state1;
  logic [7:0] res_hits0;
  logic [1:0] res_hits1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fsm101_frame_ctrl #(.FRAME_LEN(8), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready0),
    .abort(abort), .state(state0), .hit(hit0), .res_valid(res_valid0),
    .res_ready(res_ready0), .res_hits(res_hits0), .res_sat(res_sat0)
  );

  fsm101_frame_ctrl #(.FRAME_LEN(16), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready1),
    .abort(abort), .state(state1), .hit(hit1), .res_valid(res_valid1),
    .res_ready(res_ready1), .res_hits(res_hits1), .res_sat(res_sat1)
  );

  // Model: keeps the bits accepted so far in the current frame and derives everything from them.
  int m_flen[2] = '{8, 16};
  int m_max[2]  = '{255, 3};
  bit m_fb[2][32];
  int m_len[2];
  int m_hits[2];
  bit m_rv[2], m_hit[2], m_rs[2];
  int m_rh[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_state(input int k);
    int n;
    n = m_len[k];
    if (n == 0) return 1;
    if (m_fb[k][n-1]) begin
      if (n >= 3 && m_fb[k][n-3] && !m_fb[k][n-2]) return 8;
      return 2;
    end
    if (n >= 2 && m_fb[k][n-2]) return 4;
    return 1;
  endfunction

  task automatic model_step(input int k);
    bit rv_old, rr;
    int n;
    rv_old = m_rv[k];
    rr     = (k == 0) ? res_ready0 : res_ready1;
    if (reset) begin
      m_len[k] = 0; m_hits[k] = 0; m_rv[k] = 0; m_rh[k] = 0; m_rs[k] = 0; m_hit[k] = 0;
      return;
    end
    if (m_rv[k] && rr) m_rv[k] = 0;
    m_hit[k] = 0;
    if (abort) begin
      m_len[k] = 0; m_hits[k] = 0;
    end else if (in_valid && !rv_old) begin
      m_fb[k][m_len[k]] = in_bit;
      m_len[k]++;
      n = m_len[k];
      if (n >= 3 && m_fb[k][n-3] && !m_fb[k][n-2] && m_fb[k][n-1]) begin
        m_hit[k] = 1;
        m_hits[k]++;
      end
      if (n == m_flen[k]) begin
        m_rv[k] = 1;
        m_rh[k] = (m_hits[k] > m_max[k]) ? m_max[k] : m_hits[k];
        m_rs[k] = (m_hits[k] > m_max[k]);
        m_len[k] = 0; m_hits[k] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("state0", 32'(state0), 32'(model_state(0)));
    check("hit0", 32'(hit0), 32'(m_hit[0]));
    check("res_valid0", 32'(res_valid0), 32'(m_rv[0]));
    check("in_ready0", 32'(in_ready0), 32'(!m_rv[0]));
    check("res_hits0", 32'(res_hits0), 32'(m_rh[0]));
    check("res_sat0", 32'(res_sat0), 32'(m_rs[0]));
    check("state1", 32'(state1), 32'(model_state(1)));
    check("hit1", 32'(hit1), 32'(m_hit[1]));
    check("res_valid1", 32'(res_valid1), 32'(m_rv[1]));
    check("in_ready1", 32'(in_ready1), 32'(!m_rv[1]));
    check("res_hits1", 32'(res_hits1), 32'(m_rh[1]));
    check("res_sat1", 32'(res_sat1), 32'(m_rs[1]));
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; in_bit = 0; abort = 0; res_ready0 = 0; res_ready1 = 0;
    step();
    step();
    reset = 0;
  endtask

  // Sends pat[n-1] first, one bit per cycle.
  task automatic send_bits(input logic [31:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1;
      in_bit   = pat[i];
      step();
    end
    in_valid = 0;
  endtask

  initial begin
    // T1 reset
    do_reset();
    check("t1_state", 32'(state0), 32'h1);
    check("t1_in_ready", 32'(in_ready0), 32'h1);
    check("t1_res_hits", 32'(res_hits0), 32'h0);

    // T2 one full frame on dut0
    send_bits(32'b10101101, 8);
    check("t2_res_valid", 32'(res_valid0), 32'h1);
    check("t2_res_hits", 32'(res_hits0), 32'd3);
    check("t2_res_sat", 32'(res_sat0), 32'h0);
    check("t2_state", 32'(state0), 32'h1);

    // T3 backpressure, then release
    in_valid = 1; in_bit = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_in_ready", 32'(in_ready0), 32'h0);
      check("t3_state", 32'(state0), 32'h1);
      check("t3_hits", 32'(res_hits0), 32'd3);
    end
    in_valid = 0; res_ready0 = 1;
    step();
    res_ready0 = 0;
    check("t3_res_valid", 32'(res_valid0), 32'h0);
    check("t3_in_ready_back", 32'(in_ready0), 32'h1);

    // T4 frame ends in what would be C; next frame starts clean
    do_reset();
    send_bits(32'b10110110, 8);
    check("t4_state_end", 32'(state0), 32'h1);
    res_ready0 = 1;
    step();
    res_ready0 = 0;
    send_bits(32'b1, 1);
    check("t4_state_b", 32'(state0), 32'h2);
    check("t4_no_hit", 32'(hit0), 32'h0);

    // T5 abort mid-frame drops partial count and the offered bit
    do_reset();
    send_bits(32'b10101, 5);
    abort = 1; in_valid = 1; in_bit = 1;
    step();
    abort = 0; in_valid = 0;
    check("t5_abort_state", 32'(state0), 32'h1);
    send_bits(32'b10100000, 8);
    check("t5_res_valid", 32'(res_valid0), 32'h1);
    check("t5_res_hits", 32'(res_hits0), 32'd1);

    // T6 saturation on dut1 (2-bit counter, 7 hits)
    do_reset();
    res_ready0 = 1;
    send_bits(32'hAAAA, 16);
    check("t6_res_valid", 32'(res_valid1), 32'h1);
    check("t6_res_hits", 32'(res_hits1), 32'd3);
    check("t6_res_sat", 32'(res_sat1), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 599) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_bit     = 1'($urandom);
      res_ready0 = ($urandom_range(0, 2) == 0);
      res_ready1 = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
